tick_rate_ctrl: RTL and testbench

//  Runtime-programmable tick scheduler replacing fixed-rate derived clocks. One shared

---
 rtl/tick_pkg.sv | 15 +
 rtl/tick_channel.sv | 42 ++++
 rtl/tick_rate_ctrl.sv | 109 ++++++++++
 tb/tb_tick_rate_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared constants and config FSM encoding for the tick scheduler.
// The nominal prescale is derived from CLK_HZ/BASE_HZ; DIV_W sizes divisors and channel counters.
package tick_pkg;

    localparam int CLK_HZ   = 100_000_000;
    localparam int BASE_HZ  = 1000;
    localparam int DIV_W    = 16;
    localparam int CH_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counts base ticks against its divisor and emits a registered
// 1-cycle tick plus a toggle level. A clear strobe restarts the phase and wins over a due tick.
module tick_channel #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] div,
    input  logic         base_tick,
    input  logic         clr,
    output logic         tick,
    output logic         tick_lvl
);

    logic [W-1:0] cnt;

    // cnt never exceeds div-1, so W bits cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            tick     <= 1'b0;
            tick_lvl <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr) begin
                cnt      <= '0;
                tick_lvl <= 1'b0;
            end else if (div == '0) begin
                cnt <= '0;
            end else if (base_tick) begin
                if (cnt == div - W'(1)) begin
                    cnt      <= '0;
                    tick     <= 1'b1;
                    tick_lvl <= ~tick_lvl;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_rate_ctrl.sv
// Runtime-programmable tick scheduler: shared prescaler producing a base tick, a
// two-state config FSM writing per-channel divisors, and N_CH tick_channel instances.
module tick_rate_ctrl #(
    parameter int                    PRESCALE = tick_pkg::CLK_HZ / tick_pkg::BASE_HZ,
    parameter int                    N_CH     = 4,
    parameter int                    DIV_W    = tick_pkg::DIV_W,
    parameter logic [N_CH*DIV_W-1:0] DEF_DIVS = {16'd1000, 16'd500, 16'd200, 16'd1}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [tick_pkg::CH_IDX_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]              cfg_div,
    output logic                          cfg_err,
    output logic                          base_tick,
    output logic [N_CH-1:0]               tick,
    output logic [N_CH-1:0]               tick_lvl,
    output tick_pkg::cfg_state_t          dbg_state
);

    import tick_pkg::*;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     pcnt;
    cfg_state_t          state;
    logic [CH_IDX_W-1:0] lat_ch;
    logic [DIV_W-1:0]    lat_div;
    logic [N_CH-1:0]     clr_q;
    logic [DIV_W-1:0]    div_q [N_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (pcnt == PS_W'(PRESCALE - 1)) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PS_W'(1);
        end
    end

    assign base_tick = (pcnt == PS_W'(PRESCALE - 1));

    // Handshake: a config transfers on any rising clk edge where cfg_valid && cfg_ready;
    // cfg_ready is low for exactly the APPLY cycle, so a held cfg_valid re-transfers one cycle later.
    // clr_q is decoded at accept time so the channel sees its clear during APPLY and
    // restarts on the same edge that writes the new divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            lat_ch    <= '0;
            lat_div   <= '0;
            clr_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= DEF_DIVS[i*DIV_W +: DIV_W];
            end
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        lat_ch    <= cfg_ch;
                        lat_div   <= cfg_div;
                        for (int i = 0; i < N_CH; i++) begin
                            clr_q[i] <= (cfg_ch == CH_IDX_W'(i));
                        end
                        state     <= APPLY;
                        cfg_ready <= 1'b0;
                    end
                end
                APPLY: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (clr_q[i]) begin
                            div_q[i] <= lat_div;
                        end
                    end
                    cfg_err   <= ({1'b0, lat_ch} >= (CH_IDX_W + 1)'(N_CH));
                    clr_q     <= '0;
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign dbg_state = state;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_channel #(
            .W(DIV_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .div      (div_q[g]),
            .base_tick(base_tick),
            .clr      (clr_q[g]),
            .tick     (tick[g]),
            .tick_lvl (tick_lvl[g])
        );
    end

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed bench for tick_rate_ctrl with PRESCALE=10; cyc counts rising edges since reset release.
// A small per-channel timing model (first tick cycle, period, enable) gives every expected value.
module tb_tick_rate_ctrl;
    import tick_pkg::*;

    localparam int P   = 10;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [2:0]      cfg_ch = '0;
    logic [DW-1:0]   cfg_div = '0;
    logic            cfg_ready;
    logic            cfg_err;
    logic            base_tick;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  tick_lvl;
    cfg_state_t      dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int m_first [NCH];
    int m_per   [NCH];
    bit m_en    [NCH];

    tick_rate_ctrl #(
        .PRESCALE(P),
        .N_CH    (NCH),
        .DIV_W   (DW),
        .DEF_DIVS({16'd1000, 16'd500, 16'd200, 16'd1})
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .base_tick(base_tick),
        .tick     (tick),
        .tick_lvl (tick_lvl),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Base tick visible at cyc%P==P-1; default divisors 1/200/500/1000 base ticks.
    task automatic model_defaults();
        m_first = '{10, 2000, 5000, 10000};
        m_per   = '{10, 2000, 5000, 10000};
        m_en    = '{1, 1, 1, 1};
    endtask

    // Channel cleared at edge a: base ticks visible at cyc >= a count; tick follows the div-th one.
    task automatic model_cfg(input int ch, input int div, input int a);
        int c0;
        c0 = a;
        while (c0 % P != P - 1) c0++;
        m_en[ch]    = (div != 0);
        m_first[ch] = c0 + P * (div - 1) + 1;
        m_per[ch]   = P * ((div == 0) ? 1 : div);
    endtask

    function automatic bit exp_tick(input int i, input int c);
        if (!m_en[i] || c < m_first[i]) return 1'b0;
        return ((c - m_first[i]) % m_per[i]) == 0;
    endfunction

    function automatic bit exp_lvl(input int i, input int c);
        if (!m_en[i] || c < m_first[i]) return 1'b0;
        return ((((c - m_first[i]) / m_per[i]) + 1) % 2) == 1;
    endfunction

    task automatic do_cfg(input int ch, input int div, output int a);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = DW'(div);
        step();
        cfg_valid = 1'b0;
        step();
        a = cyc;
    endtask

    task automatic test_reset();
        int first_bt;
        int first_t3;
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if (tick !== '0 || tick_lvl !== '0 || base_tick !== 1'b0 || cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: tick=%b lvl=%b bt=%b err=%b, want all 0", tick, tick_lvl, base_tick, cfg_err);
        end
        vectors++;
        if (cfg_ready !== 1'b1 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_fsm: ready=%b state=%0d, want ready=1 state=IDLE", cfg_ready, dbg_state);
        end
        rst_n = 1'b1;
        cyc = 0;
        model_defaults();
        first_bt = -1;
        first_t3 = -1;
        for (int n = 0; n < 10005; n++) begin
            step();
            if (base_tick === 1'b1 && first_bt < 0) first_bt = cyc;
            if (tick[3] === 1'b1 && first_t3 < 0) first_t3 = cyc;
            vectors++;
            if (base_tick !== (cyc % P == P - 1)) begin
                miscompares++;
                $display("FAIL reset_base_tick cyc=%0d: got %b want %b", cyc, base_tick, (cyc % P == P - 1));
            end
            for (int i = 0; i < NCH; i++) begin
                vectors++;
                if (tick[i] !== exp_tick(i, cyc) || tick_lvl[i] !== exp_lvl(i, cyc)) begin
                    miscompares++;
                    $display("FAIL reset_run ch%0d cyc=%0d: tick=%b lvl=%b want %b %b", i, cyc, tick[i], tick_lvl[i], exp_tick(i, cyc), exp_lvl(i, cyc));
                end
            end
        end
        // Visible during the 10th clock period after release; ch3 tick in period 10001.
        vectors++;
        if (first_bt != 9) begin
            miscompares++;
            $display("FAIL first_base_tick: got cyc %0d want 9", first_bt);
        end
        vectors++;
        if (first_t3 != 10000) begin
            miscompares++;
            $display("FAIL first_tick_ch3: got cyc %0d want 10000", first_t3);
        end
    endtask

    task automatic test_cfg_ch2();
        int a;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ch2_ready_before: got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_div   = 16'd3;
        step();
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_ready !== 1'b0 || dbg_state !== APPLY) begin
            miscompares++;
            $display("FAIL ch2_apply: ready=%b state=%0d want 0 APPLY", cfg_ready, dbg_state);
        end
        step();
        a = cyc;
        vectors++;
        if (cfg_ready !== 1'b1 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL ch2_idle: ready=%b state=%0d want 1 IDLE", cfg_ready, dbg_state);
        end
        model_cfg(2, 3, a);
        while (cyc < 12005) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                vectors++;
                if (tick[i] !== exp_tick(i, cyc) || tick_lvl[i] !== exp_lvl(i, cyc)) begin
                    miscompares++;
                    $display("FAIL ch2_run ch%0d cyc=%0d: tick=%b lvl=%b want %b %b", i, cyc, tick[i], tick_lvl[i], exp_tick(i, cyc), exp_lvl(i, cyc));
                end
            end
        end
    endtask

    task automatic test_disable();
        int a;
        do_cfg(1, 0, a);
        model_cfg(1, 0, a);
        for (int n = 0; n < 1000; n++) begin
            step();
            vectors++;
            if (tick[1] !== 1'b0 || tick_lvl[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL disable_ch1 cyc=%0d: tick=%b lvl=%b want 0 0", cyc, tick[1], tick_lvl[1]);
            end
        end
        do_cfg(1, 2, a);
        model_cfg(1, 2, a);
        for (int n = 0; n < 60; n++) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                vectors++;
                if (tick[i] !== exp_tick(i, cyc) || tick_lvl[i] !== exp_lvl(i, cyc)) begin
                    miscompares++;
                    $display("FAIL reenable ch%0d cyc=%0d: tick=%b lvl=%b want %b %b", i, cyc, tick[i], tick_lvl[i], exp_tick(i, cyc), exp_lvl(i, cyc));
                end
            end
        end
    endtask

    task automatic test_bad_ch();
        cfg_valid = 1'b1;
        cfg_ch    = 3'd5;
        cfg_div   = 16'd7;
        step();
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_ch_accept: ready=%b err=%b want 0 0", cfg_ready, cfg_err);
        end
        step();
        vectors++;
        if (cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_ch_err_pulse: got %b want 1", cfg_err);
        end
        step();
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_ch_err_clear: got %b want 0", cfg_err);
        end
        for (int n = 0; n < 100; n++) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                vectors++;
                if (tick[i] !== exp_tick(i, cyc) || tick_lvl[i] !== exp_lvl(i, cyc)) begin
                    miscompares++;
                    $display("FAIL bad_ch_run ch%0d cyc=%0d: tick=%b lvl=%b want %b %b", i, cyc, tick[i], tick_lvl[i], exp_tick(i, cyc), exp_lvl(i, cyc));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int a;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_div   = 16'd3;
        step();
        vectors++;
        if (cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first_accept: ready=%b want 0", cfg_ready);
        end
        step();
        vectors++;
        if (cfg_ready !== 1'b1 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL b2b_apply_not_accepted: ready=%b state=%0d want 1 IDLE", cfg_ready, dbg_state);
        end
        step();
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_ready !== 1'b0 || dbg_state !== APPLY) begin
            miscompares++;
            $display("FAIL b2b_second_accept: ready=%b state=%0d want 0 APPLY", cfg_ready, dbg_state);
        end
        step();
        a = cyc;
        model_cfg(2, 3, a);
        for (int n = 0; n < 70; n++) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                vectors++;
                if (tick[i] !== exp_tick(i, cyc) || tick_lvl[i] !== exp_lvl(i, cyc)) begin
                    miscompares++;
                    $display("FAIL b2b_run ch%0d cyc=%0d: tick=%b lvl=%b want %b %b", i, cyc, tick[i], tick_lvl[i], exp_tick(i, cyc), exp_lvl(i, cyc));
                end
            end
        end
    endtask

    task automatic test_collision();
        int a;
        int next_t0;
        while (cyc % P != P - 2) step();
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_div   = 16'd1;
        step();
        cfg_valid = 1'b0;
        vectors++;
        if (base_tick !== 1'b1 || dbg_state !== APPLY) begin
            miscompares++;
            $display("FAIL collide_align: bt=%b state=%0d want 1 APPLY", base_tick, dbg_state);
        end
        step();
        a = cyc;
        model_cfg(0, 1, a);
        vectors++;
        if (tick[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_suppressed: tick0=%b want 0", tick[0]);
        end
        next_t0 = -1;
        for (int n = 0; n < 25; n++) begin
            step();
            if (tick[0] === 1'b1 && next_t0 < 0) next_t0 = cyc;
            for (int i = 0; i < NCH; i++) begin
                vectors++;
                if (tick[i] !== exp_tick(i, cyc) || tick_lvl[i] !== exp_lvl(i, cyc)) begin
                    miscompares++;
                    $display("FAIL collide_run ch%0d cyc=%0d: tick=%b lvl=%b want %b %b", i, cyc, tick[i], tick_lvl[i], exp_tick(i, cyc), exp_lvl(i, cyc));
                end
            end
        end
        vectors++;
        if (next_t0 != a + P) begin
            miscompares++;
            $display("FAIL collide_next_tick: got cyc %0d want %0d", next_t0, a + P);
        end
    endtask

    task automatic test_reset_mid();
        int a;
        int n;
        n = 0;
        while (tick_lvl[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (tick_lvl[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_wait_lvl: tick_lvl0=%b want 1 within 40 cycles", tick_lvl[0]);
        end
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_div   = 16'd4;
        step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tick !== '0 || tick_lvl !== '0 || base_tick !== 1'b0 || cfg_err !== 1'b0
            || cfg_ready !== 1'b1 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: tick=%b lvl=%b bt=%b err=%b ready=%b state=%0d", tick, tick_lvl, base_tick, cfg_err, cfg_ready, dbg_state);
        end
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        model_defaults();
        step();
        vectors++;
        if (cfg_ready !== 1'b0 || dbg_state !== APPLY) begin
            miscompares++;
            $display("FAIL mid_reset_reaccept: ready=%b state=%0d want 0 APPLY", cfg_ready, dbg_state);
        end
        cfg_valid = 1'b0;
        step();
        a = cyc;
        model_cfg(2, 4, a);
        while (cyc < 2005) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                vectors++;
                if (tick[i] !== exp_tick(i, cyc) || tick_lvl[i] !== exp_lvl(i, cyc)) begin
                    miscompares++;
                    $display("FAIL mid_reset_run ch%0d cyc=%0d: tick=%b lvl=%b want %b %b", i, cyc, tick[i], tick_lvl[i], exp_tick(i, cyc), exp_lvl(i, cyc));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_ch2();
        test_disable();
        test_bad_ch();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
